// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if
// Purpose: request/response bundle between the requester (alu_controller side
//          plus EX/MEM consumer) and the multicycle ALU.
// Signals:
//   in_valid/in_ready          request handshake
//   alu_controller[3:0]        operation code
//   operand_a/operand_b[XLEN]  operands (shift amount = operand_b[4:0])
//   out_valid/out_ready        result handshake
//   result[XLEN], zero, illegal  result bundle, qualified by out_valid
interface multicycle_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_controller;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_controller, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_controller, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu
// Purpose: execute-stage ALU with valid/ready handshakes. Add/sub/logic/compare
//          finish in one cycle; shifts walk one bit per cycle so no barrel
//          shifter sits on the EX path.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - multicycle_alu_if slave modport (request, result, handshakes)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | in_ready=1, waiting for a request
// SHIFT  | shifting the working register, one position per cycle
// DONE   | out_valid=1, result frozen until out_ready
module multicycle_alu #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_alu_if.slave   bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      op_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  logic [XLEN-1:0] alu_d;
  logic            illegal_d;
  logic            is_shift_d;
  logic [4:0]      shamt_d;
  logic [XLEN-1:0] step_d;

  assign shamt_d = bus.operand_b[4:0];

  // Single-cycle result computed from the live inputs; only registered on accept.
  // For shifts this is the unshifted operand, which is also the shamt=0 answer.
  always_comb begin
    alu_d      = '0;
    illegal_d  = 1'b0;
    is_shift_d = 1'b0;
    unique case (bus.alu_controller)
      OP_ADD:  alu_d = bus.operand_a + bus.operand_b;
      OP_SUB:  alu_d = bus.operand_a - bus.operand_b;
      OP_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(bus.operand_a) < $signed(bus.operand_b))};
      OP_SLTU: alu_d = {{(XLEN-1){1'b0}}, (bus.operand_a < bus.operand_b)};
      OP_XOR:  alu_d = bus.operand_a ^ bus.operand_b;
      OP_OR:   alu_d = bus.operand_a | bus.operand_b;
      OP_AND:  alu_d = bus.operand_a & bus.operand_b;
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_d      = bus.operand_a;
        is_shift_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // One-position step of the working register.
  always_comb begin
    step_d = result_q;
    case (op_q)
      OP_SLL:  step_d = {result_q[XLEN-2:0], 1'b0};
      OP_SRL:  step_d = {1'b0, result_q[XLEN-1:1]};
      OP_SRA:  step_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: step_d = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q      <= bus.alu_controller;
            cnt_q     <= shamt_d;
            result_q  <= alu_d;
            illegal_q <= illegal_d;
            if (is_shift_d && (shamt_d != 5'd0)) state_q <= S_SHIFT;
            else                                 state_q <= S_DONE;
          end
        end
        S_SHIFT: begin
          result_q <= step_d;
          cnt_q    <= cnt_q - 5'd1;
          // Down-counter terminal count: the 1->0 step is the last shift.
          if (cnt_q == 5'd1) state_q <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu
// Purpose: self-checking bench for multicycle_alu. A transaction-level model
//          (operation -> result and latency) is compared against the DUT every
//          cycle; directed vectors carry hand-computed literal expectations.
module tb_multicycle_alu;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  multicycle_alu_if #(.XLEN(32)) bus ();

  multicycle_alu #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    r   = 32'd0;
    ill = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << b[4:0];
      4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> b[4:0];
      4'd7: r = 32'($signed(a) >>> b[4:0]);
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  int          cyc;
  bit          seen_rst;
  bit          m_busy;
  int          m_done_edge;
  logic [31:0] m_res;
  logic        m_ill;

  // Model advances on each rising edge using the same sampled inputs as the DUT.
  always @(posedge clk) begin
    logic [32:0] r;
    cyc++;
    if (rst) begin
      seen_rst = 1'b1;
      m_busy   = 1'b0;
    end else if (m_busy && cyc > m_done_edge && bus.out_ready) begin
      m_busy = 1'b0;
    end else if (!m_busy && bus.in_valid) begin
      r           = ref_alu(bus.alu_controller, bus.operand_a, bus.operand_b);
      m_res       = r[31:0];
      m_ill       = r[32];
      m_busy      = 1'b1;
      m_done_edge = cyc + ref_lat(bus.alu_controller, bus.operand_b) - 1;
    end
  end

  always @(negedge clk) begin
    bit exp_ov;
    if (seen_rst && !rst) begin
      exp_ov = m_busy && (cyc >= m_done_edge);
      check("mdl_in_ready", {31'd0, bus.in_ready}, {31'd0, !m_busy});
      check("mdl_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      if (exp_ov) begin
        check("mdl_result", bus.result, m_res);
        check("mdl_zero", {31'd0, bus.zero}, {31'd0, (m_res == 32'd0)});
        check("mdl_illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input logic exp_ill);
    int lat;
    bit got;
    @(negedge clk);
    bus.in_valid       = 1'b1;
    bus.alu_controller = op;
    bus.operand_a      = a;
    bus.operand_b      = b;
    bus.out_ready      = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid       = 1'b0;
    bus.alu_controller = 4'($urandom);
    bus.operand_a      = $urandom;
    bus.operand_b      = $urandom;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) got = 1'b1;
      else check({name, "_in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: out_valid not seen after %0d cycles, required latency %0d",
               name, lat, exp_lat);
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, bus.result, exp_res);
    check({name, "_zero"}, {31'd0, bus.zero}, {31'd0, (exp_res == 32'd0)});
    check({name, "_illegal"}, {31'd0, bus.illegal}, {31'd0, exp_ill});
  endtask

  task automatic consume(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({name, "_idle_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_ill);
    issue_op(name, op, a, b, exp_res, exp_lat, exp_ill);
    consume(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    tests              = 0;
    fails              = 0;
    cyc                = 0;
    seen_rst           = 1'b0;
    m_busy             = 1'b0;
    m_done_edge        = 0;
    m_res              = 32'd0;
    m_ill              = 1'b0;
    rst                = 1'b1;
    bus.in_valid       = 1'b0;
    bus.alu_controller = 4'd0;
    bus.operand_a      = 32'd0;
    bus.operand_b      = 32'd0;
    bus.out_ready      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    rst = 1'b0;

    run_op("sub",      4'd1, 32'd5,          32'd7,          32'hFFFF_FFFE, 1,  1'b0);
    run_op("slt",      4'd3, 32'hFFFF_FFFF,  32'd1,          32'd1,         1,  1'b0);
    run_op("sltu",     4'd4, 32'hFFFF_FFFF,  32'd1,          32'd0,         1,  1'b0);
    run_op("sra4",     4'd7, 32'h8000_0000,  32'd4,          32'hF800_0000, 5,  1'b0);
    run_op("sll31",    4'd2, 32'd1,          32'd31,         32'h8000_0000, 32, 1'b0);
    run_op("srl0",     4'd6, 32'h8000_0000,  32'd0,          32'h8000_0000, 1,  1'b0);
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,         1,  1'b0);
    run_op("xor",      4'd5, 32'h1234_5678,  32'hFFFF_0000,  32'hEDCB_5678, 1,  1'b0);
    run_op("or",       4'd8, 32'h00F0_000F,  32'h0F00_00F0,  32'h0FF0_00FF, 1,  1'b0);
    run_op("sra31",    4'd7, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF, 32, 1'b0);
    run_op("srl3hi",   4'd6, 32'hF000_0000,  32'hFFFF_FFE3,  32'h1E00_0000, 4,  1'b0);
    run_op("sll1",     4'd2, 32'h4000_0001,  32'd1,          32'h8000_0002, 2,  1'b0);
    run_op("ill_1010", 4'hA, 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,         1,  1'b1);
    run_op("ill_1111", 4'hF, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,         1,  1'b1);

    // Backpressure: result must stay frozen, and a request raised during DONE
    // is only accepted on the edge after the consuming edge.
    issue_op("and", 4'd9, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1, 1'b0);
    bus.in_valid       = 1'b1;
    bus.alu_controller = 4'd0;
    bus.operand_a      = 32'h10;
    bus.operand_b      = 32'h20;
    repeat (6) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_result", bus.result, 32'h0000_00F0);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_next_result", bus.result, 32'h0000_0030);
    consume("bp_next");

    // Reset in the middle of a long shift abandons it.
    @(negedge clk);
    bus.in_valid       = 1'b1;
    bus.alu_controller = 4'd6;
    bus.operand_a      = 32'hFFFF_0000;
    bus.operand_b      = 32'd20;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_shift_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_shift_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_shift_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_shift_result", bus.result, 32'd0);
    check("rst_shift_illegal", {31'd0, bus.illegal}, 32'd0);
    repeat (25) begin
      @(negedge clk);
      check("rst_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    run_op("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

- Handshaked execute-stage ALU that consumes the 4-bit `alu_controller` code and operands.
- ADD/SUB/logic/compare complete in one cycle.
- Shifts run iteratively, one bit position per cycle, so the 32-bit barrel shifter leaves the EX critical path.
- Sits between `alu_controller` and the EX/MEM pipeline register; the hazard unit stalls on `in_ready`/`out_valid`.

## Interface

Parameters:
- `XLEN`, 32, operand/result width (shift amount is always the low 5 bits of `operand_b`)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  input  1  clock; all state changes on the rising edge
  - `rst`  input  1  synchronous, active-high reset
- Input side:
  - `in_valid`  input  1  operation request
  - `in_ready`  output  1  unit can accept a request
  - `alu_controller`  input  4  operation code
  - `operand_a`  input  XLEN  rs1 / first operand
  - `operand_b`  input  XLEN  rs2 or immediate
- Output side:
  - `out_valid`  output  1  `result` is valid
  - `out_ready`  input  1  consumer accepts the result
  - `result`  output  XLEN  operation result
  - `zero`  output  1  `result == 0`, for branch resolution
  - `illegal`  output  1  unsupported code was accepted; qualified by `out_valid`

## Operation

- Code map:
  - 0000 ADD
  - 0001 SUB
  - 0010 SLL
  - 0011 SLT
  - 0100 SLTU
  - 0101 XOR
  - 0110 SRL
  - 0111 SRA
  - 1000 OR
  - 1001 AND
  - 1010–1111 illegal: `result` = 0, `illegal` = 1
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT compares signed; SLTU compares unsigned. Both produce 0 or 1 zero-extended.
  - SRA replicates bit XLEN-1 on every step.
- Accept:
  - A request is accepted on an edge where `in_valid && in_ready`.
  - At acceptance, the opcode, operands and shift count `shamt = operand_b[4:0]` are registered.
  - Input ports are ignored at all other times.
- States:
  - IDLE: `in_ready` = 1, `out_valid` = 0.
    - On accept of a non-shift op, or a shift with `shamt` = 0, compute the result and go to DONE.
    - On accept of a shift with `shamt` ≥ 1, go to SHIFT with counter = `shamt`.
  - SHIFT: `in_ready` = 0.
    - Each edge shifts the working register one position (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and decrements the counter.
    - On the edge where the counter goes 1→0, go to DONE.
  - DONE: `out_valid` = 1.
    - `result`, `zero` and `illegal` are held stable until the edge with `out_ready` = 1, which returns the unit to IDLE.
- `in_ready` is high only in IDLE. No new request is accepted in DONE, even when `out_ready` = 1.
- Reset:
  - Values after reset: state IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, `zero` = 1, `illegal` = 0.
  - Reset in SHIFT or DONE abandons the operation; no `out_valid` pulse follows.

## Timing

- Accept on edge N, non-shift op or `shamt` = 0: `out_valid` is high in the cycle after edge N (latency 1).
- Accept on edge N, shift with `shamt` = k ≥ 1: `out_valid` is high in the cycle after edge N+k (latency k+1; worst case 32).
- `out_ready` held high: the result is consumed on the first DONE edge, and `in_ready` returns one cycle later.
- Maximum throughput is one op per 2 cycles.
- `out_ready` low: DONE persists indefinitely with outputs frozen.
- `out_ready` during IDLE or SHIFT has no effect.
- `in_valid` during SHIFT or DONE is not accepted. The requester must hold it (standard valid/ready); the unit never drops an accepted op.
- `rst` has priority over every other input on the same edge.
- All outputs come from registers or state decode; there is no combinational path from inputs to outputs.

## Test plan

- Post-reset check: `in_ready` = 1, `out_valid` = 0, `result` = 0, `zero` = 1, `illegal` = 0.
- SUB: a = 5, b = 7 → `result` = 0xFFFFFFFE, `zero` = 0, `out_valid` one cycle after accept.
- Compares: SLT with a = 0xFFFFFFFF, b = 1 → `result` = 1. SLTU with the same operands → `result` = 0.
- Shifts:
  - SRA: a = 0x80000000, b = 4 → 0xF8000000, `out_valid` 5 cycles after accept, `in_ready` = 0 throughout.
  - SLL: a = 1, b = 31 → 0x80000000 at latency 32.
  - SRL: a = 0x80000000, b = 0 → 0x80000000 at latency 1.
- Backpressure:
  - AND: a = 0xF0F0, b = 0x0FF0 → `result` = 0x00F0.
  - Hold `out_ready` = 0 for 6 cycles: `out_valid` and `result` remain stable and `in_ready` stays 0.
  - A pending `in_valid` is accepted only one cycle after the `out_ready` edge.
- Illegal code and reset:
  - Code 4'b1111 → `result` = 0, `zero` = 1, `illegal` = 1.
  - SRL with `shamt` = 20, `rst` asserted 3 cycles after accept → IDLE next cycle, no `out_valid`; the next ADD 2+3 returns 5.
